alu_exec_seq: RTL and testbench
===============================

ALU_EXEC_SEQ -- requirements
Module: alu_exec_seq

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 instr_valid  input  1  instr holds a valid instruction.
REQ-004 instr  input  16  [15:13] op, [12:11] rd, [10:9] ra, [1:0] rb, [7:0] imm (LDI only).
REQ-005 instr_ready  output  1  block accepts an instruction this cycle.
REQ-006 alu_a  output  8  registered operand A to the downstream ALU.
REQ-007 alu_b  output  8  registered operand B to the downstream ALU.
REQ-008 alu_op  output  3  registered ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor.
REQ-009 alu_result  input  8  combinational ALU result for alu_a/alu_b/alu_op.
REQ-010 done  output  1  one-cycle pulse when an instruction retires.
REQ-011 err  output  1  sticky illegal-opcode flag.
REQ-012 flag_z, flag_n  output  1 each  zero and negative (bit 7) of last written value.
REQ-013 dbg_sel  input  2  register-file debug read select.
REQ-014 dbg_data  output  8  combinational read of register dbg_sel.

Function
REQ-015 Register file: four 8-bit registers r0..r3; only writer is the WB state.
REQ-016 FSM states: IDLE, READ, EXEC, WB; one state per cycle, no stalls.
REQ-017 IDLE: instr_ready=1; on instr_valid&&instr_ready, latch instr, go READ; else stay.
REQ-018 instr_ready=0 in READ, EXEC, WB; instr_valid ignored there.
REQ-019 READ: alu_a<=r[ra], alu_b<=r[rb], alu_op<=op (op 000-100); go EXEC.
REQ-020 EXEC: capture alu_result into an internal 8-bit wb register; go WB.
REQ-021 LDI (op 101): EXEC captures imm instead of alu_result; alu_a/alu_b/alu_op unchanged.
REQ-022 NOP (op 110): no register write, flags unchanged; done still pulses.
REQ-023 Illegal op 111: no register write, flags unchanged, err<=1; done still pulses.
REQ-024 WB: r[rd]<=wb value (ops 000-101), update flags, done=1 for that cycle, go IDLE.
REQ-025 Latency: instr accepted at edge N, r[rd] and done visible after edge N+3; next accept at N+4 earliest.
REQ-026 Arithmetic wraps modulo 256 (add 0xFF+0x01=0x00, sub 0x00-0x01=0xFF); no carry kept.
REQ-027 rd equal to ra or rb: operands already latched in READ, so the old value is used.
REQ-028 err clears only on reset.
REQ-029 dbg_data reflects a WB write from the cycle after the write edge.

Reset
REQ-030 rst_n low: FSM to IDLE immediately; r0..r3, alu_a, alu_b, wb, flags, err=0; alu_op=000; done=0; instr_ready=1 after release.
REQ-031 Reset mid-instruction (READ/EXEC/WB) aborts it: no register write, no done pulse.
REQ-032 Deassertion is taken synchronously; the first accept is possible on the first edge with rst_n high.

Configuration
REQ-033 Macro ALU_EXEC_SEQ_FLAGS_EN: when defined, flag_z/flag_n are registers updated in WB per REQ-024.
REQ-034 When ALU_EXEC_SEQ_FLAGS_EN is undefined, no flag registers are built and flag_z=flag_n=0 constantly; all other behaviour is identical.

Verification
REQ-035 Reset, LDI r1,0x05; LDI r2,0x03; ADD r0=r1+r2 -> dbg r0=0x08, done once per instr, each 3 cycles after accept.
REQ-036 LDI r1,0x00; LDI r2,0x01; SUB r3=r1-r2 -> r3=0xFF, flag_n=1, flag_z=0 (macro on); flags 0 (macro off).
REQ-037 r1=0xF0, XOR r1=r1^r1 -> r1=0x00, flag_z=1; instr_valid held high throughout -> only one accept per 4 cycles.
REQ-038 Op 111 with rd=r2 -> r2 unchanged, err=1, done pulses; subsequent valid ADD still executes and err stays 1.
REQ-039 Assert rst_n low in EXEC of ADD r0 -> r0 stays 0x00, no done, instr_ready=1 after release.
REQ-040 ADD 0xFF+0x01 into r3 -> r3=0x00, flag_z=1; alu_op=000 and alu_a=0xFF during EXEC.

Source files
------------

// File: rtl/alu_exec_seq.sv
// Four-state sequencer that feeds an external combinational ALU and writes back to a 4x8 regfile.
// Optional build macro ALU_EXEC_SEQ_FLAGS_EN adds zero/negative flag registers.
module alu_exec_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_result,
  output logic        done,
  output logic        err,
  output logic        flag_z,
  output logic        flag_n,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpLdi = 3'b101;
  localparam logic [2:0] OpIll = 3'b111;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [1:0]  rd_q;
  logic [1:0]  ra_q;
  logic [1:0]  rb_q;
  logic [7:0]  imm_q;
  logic [7:0]  regs_q [4];
  logic [7:0]  alu_a_q;
  logic [7:0]  alu_b_q;
  logic [2:0]  alu_op_q;
  logic [7:0]  wb_q;
  logic        done_q;
  logic        err_q;

  logic is_alu_op;
  logic is_write_op;

  // Bit 8 of the instruction word carries no field.
  logic unused_instr;
  assign unused_instr = instr[8];

  assign is_alu_op   = (op_q <= OpXor);
  assign is_write_op = (op_q <= OpLdi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      imm_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      wb_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (instr_valid) begin
            op_q    <= instr[15:13];
            rd_q    <= instr[12:11];
            ra_q    <= instr[10:9];
            rb_q    <= instr[1:0];
            imm_q   <= instr[7:0];
            state_q <= StRead;
          end
        end
        StRead: begin
          // Operands are sampled here, so rd == ra/rb always sees the old value.
          if (is_alu_op) begin
            alu_a_q  <= regs_q[ra_q];
            alu_b_q  <= regs_q[rb_q];
            alu_op_q <= op_q;
          end
          state_q <= StExec;
        end
        StExec: begin
          if (op_q == OpLdi) begin
            wb_q <= imm_q;
          end else if (is_alu_op) begin
            wb_q <= alu_result;
          end
          state_q <= StWb;
        end
        StWb: begin
          if (is_write_op) begin
            regs_q[rd_q] <= wb_q;
          end
          if (op_q == OpIll) begin
            err_q <= 1'b1;
          end
          // done rises with the register write so both are seen together.
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALU_EXEC_SEQ_FLAGS_EN
  logic flag_z_q;
  logic flag_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if ((state_q == StWb) && is_write_op) begin
      flag_z_q <= (wb_q == 8'h00);
      flag_n_q <= wb_q[7];
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

  assign instr_ready = (state_q == StIdle);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_data    = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq: vector table for single instructions plus hand-written
// sequences for illegal/NOP ops, back-to-back valid, and mid-instruction reset.
module tb_alu_exec_seq;

`ifdef ALU_EXEC_SEQ_FLAGS_EN
  localparam bit FlagsOn = 1'b1;
`else
  localparam bit FlagsOn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic [7:0]  alu_result;
  logic        done;
  logic        err;
  logic        flag_z;
  logic        flag_n;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  int checks = 0;
  int errors = 0;

  alu_exec_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .done       (done),
    .err        (err),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream combinational ALU.
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  typedef struct {
    logic [15:0] ins;
    logic [1:0]  rd;
    logic [7:0]  val;
    logic        z;
    logic        n;
    bit          alu;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] ra, input logic [1:0] rb,
                                     input logic [7:0] imm);
    return {op, rd, ra, 1'b0, imm | {6'b0, rb}};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reg(input string name, input logic [1:0] sel, input logic [7:0] exp);
    dbg_sel = sel;
    #1;
    chk(name, {24'b0, dbg_data}, {24'b0, exp});
  endtask

  task automatic chk_flags(input string name, input logic z, input logic n);
    chk(name, {30'b0, flag_z, flag_n}, {30'b0, z & FlagsOn, n & FlagsOn});
  endtask

  // Starts at a negedge; returns at the negedge where done is expected high.
  task automatic issue(input string name, input logic [15:0] ins, input bit chk_alu,
                       input logic [7:0] ea, input logic [7:0] eb, input logic [2:0] eop);
    int   w;
    logic [3:0] pat;
    w = 0;
    while (!instr_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) begin
      chk({name, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pat[3-k] = done;
      if (k == 1 && chk_alu) begin
        chk({name, "_exec_alu"}, {13'b0, alu_op, alu_a, alu_b}, {13'b0, eop, ea, eb});
      end
    end
    chk({name, "_done_latency"}, {28'b0, pat}, 32'h1);
  endtask

  initial begin
    int accepts;
    int dones;

    vecs[0]  = '{mk(3'b101, 2'd1, 2'd0, 2'd0, 8'h05), 2'd1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0};
    vecs[1]  = '{mk(3'b101, 2'd2, 2'd0, 2'd0, 8'h03), 2'd2, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0};
    vecs[2]  = '{mk(3'b000, 2'd0, 2'd1, 2'd2, 8'h00), 2'd0, 8'h08, 1'b0, 1'b0, 1'b1, 8'h05, 8'h03, 3'd0};
    vecs[3]  = '{mk(3'b101, 2'd1, 2'd0, 2'd0, 8'h00), 2'd1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0};
    vecs[4]  = '{mk(3'b101, 2'd2, 2'd0, 2'd0, 8'h01), 2'd2, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0};
    vecs[5]  = '{mk(3'b001, 2'd3, 2'd1, 2'd2, 8'h00), 2'd3, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 3'd1};
    vecs[6]  = '{mk(3'b101, 2'd1, 2'd0, 2'd0, 8'hF0), 2'd1, 8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0};
    vecs[7]  = '{mk(3'b100, 2'd1, 2'd1, 2'd1, 8'h00), 2'd1, 8'h00, 1'b1, 1'b0, 1'b1, 8'hF0, 8'hF0, 3'd4};
    vecs[8]  = '{mk(3'b010, 2'd2, 2'd3, 2'd2, 8'h00), 2'd2, 8'h01, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h01, 3'd2};
    vecs[9]  = '{mk(3'b011, 2'd0, 2'd0, 2'd3, 8'h00), 2'd0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h08, 8'hFF, 3'd3};
    vecs[10] = '{mk(3'b101, 2'd3, 2'd0, 2'd0, 8'hFF), 2'd3, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0};
    vecs[11] = '{mk(3'b101, 2'd2, 2'd0, 2'd0, 8'h01), 2'd2, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0};
    vecs[12] = '{mk(3'b000, 2'd3, 2'd3, 2'd2, 8'h00), 2'd3, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h01, 3'd0};

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_sel     = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_outputs", {instr_ready, done, err, flag_z, flag_n, alu_op, alu_a, alu_b},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00});
    for (int r = 0; r < 4; r++) begin
      chk_reg($sformatf("reset_r%0d", r), 2'(r), 8'h00);
    end
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      issue($sformatf("vec%0d", i), vecs[i].ins, vecs[i].alu, vecs[i].a, vecs[i].b, vecs[i].op);
      chk_reg($sformatf("vec%0d_rd", i), vecs[i].rd, vecs[i].val);
      chk_flags($sformatf("vec%0d_flags", i), vecs[i].z, vecs[i].n);
      chk($sformatf("vec%0d_err", i), {31'b0, err}, 32'd0);
      @(negedge clk);
    end

    // Illegal opcode targeting r2, then a normal ADD and a NOP.
    issue("illegal", mk(3'b111, 2'd2, 2'd3, 2'd3, 8'h00), 1'b0, 8'h00, 8'h00, 3'd0);
    chk_reg("illegal_r2", 2'd2, 8'h01);
    chk("illegal_err", {31'b0, err}, 32'd1);
    chk_flags("illegal_flags", 1'b1, 1'b0);
    @(negedge clk);
    issue("add_after_err", mk(3'b000, 2'd0, 2'd2, 2'd2, 8'h00), 1'b1, 8'h01, 8'h01, 3'd0);
    chk_reg("add_after_err_r0", 2'd0, 8'h02);
    chk("add_after_err_err", {31'b0, err}, 32'd1);
    chk_flags("add_after_err_flags", 1'b0, 1'b0);
    @(negedge clk);
    issue("nop", mk(3'b110, 2'd0, 2'd2, 2'd2, 8'h00), 1'b0, 8'h00, 8'h00, 3'd0);
    chk_reg("nop_r0", 2'd0, 8'h02);
    chk_flags("nop_flags", 1'b0, 1'b0);
    @(negedge clk);

    // instr_valid held high: one accept per four cycles.
    issue("ldi_f0", mk(3'b101, 2'd1, 2'd0, 2'd0, 8'hF0), 1'b0, 8'h00, 8'h00, 3'd0);
    @(negedge clk);
    accepts     = 0;
    dones       = 0;
    instr_valid = 1'b1;
    instr       = mk(3'b100, 2'd1, 2'd1, 2'd1, 8'h00);
    for (int i = 0; i <= 12; i++) begin
      if (instr_ready && i < 12) accepts++;
      if (done) dones++;
      if (i == 12) instr_valid = 1'b0;
      else @(negedge clk);
    end
    instr = '0;
    chk("held_valid_accepts", accepts, 3);
    chk("held_valid_dones", dones, 3);
    chk_reg("held_valid_r1", 2'd1, 8'h00);
    chk_flags("held_valid_flags", 1'b1, 1'b0);
    @(negedge clk);

    // Reset clears sticky err; then reset during EXEC aborts an ADD.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("err_cleared", {31'b0, err}, 32'd0);
    @(negedge clk);
    issue("ldi_07", mk(3'b101, 2'd1, 2'd0, 2'd0, 8'h07), 1'b0, 8'h00, 8'h00, 3'd0);
    chk_reg("ldi_07_r1", 2'd1, 8'h07);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = mk(3'b000, 2'd0, 2'd1, 2'd1, 8'h00);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_reset", {30'b0, instr_ready, done}, {30'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", dones, 0);
    chk_reg("abort_r0", 2'd0, 8'h00);
    chk("abort_ready", {31'b0, instr_ready}, 32'd1);
    issue("post_reset_ldi", mk(3'b101, 2'd0, 2'd0, 2'd0, 8'h5A), 1'b0, 8'h00, 8'h00, 3'd0);
    chk_reg("post_reset_r0", 2'd0, 8'h5A);
    chk_flags("post_reset_flags", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
